image_frame_sequencer: RTL and testbench

Sequences one image frame through the shared 8192x8 dual-port frame BRAM. In LOAD it writes strobed input pixels to consecutive addresses. In READOUT it streams the whole frame back out through a valid/ready interface to the downstream filter stage. It sits between the pixel source and the processing pipeline and is the only master of both BRAM ports.

---
 rtl/frame_seq_pkg.sv | 19 +
 rtl/image_frame_sequencer_sync_fifo.sv | 54 +++++
 rtl/image_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_image_frame_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and defaults for the frame sequencer and its output buffer.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READOUT
  } state_t;

  localparam int unsigned DEFAULT_ADDR_W       = 13;
  localparam int unsigned DEFAULT_DATA_W       = 8;
  localparam int unsigned DEFAULT_FRAME_PIXELS = 4096;

  // Width needed to hold an occupancy value from 0 up to depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/image_frame_sequencer_sync_fifo.sv
// Small synchronous FIFO; push and pop in the same cycle are allowed when full or empty.
module sync_fifo
  import frame_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [DATA_W-1:0]              din,
  input  logic                           pop,
  output logic [DATA_W-1:0]              dout,
  output logic [fifo_cnt_w(DEPTH)-1:0]   count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = fifo_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_frame_sequencer.sv
// Loads one frame of strobed pixels into the frame BRAM, then streams it back
// out in address order through a credit-limited valid/ready buffer.
module image_frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned FIFO_DEPTH   = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] image_in,
  input  logic              new_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [ADDR_W-1:0] bram_raddr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam int unsigned      FCW      = fifo_cnt_w(FIFO_DEPTH);
  localparam int unsigned      UW       = FCW + 1;
  localparam logic [CNT_W-1:0] NUM_PIX  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  state_t            state;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] raddr_q;
  logic [FCW-1:0]    count;
  logic [UW-1:0]     used;
  logic              empty;
  logic              full;
  logic              issue;
  logic              pop;

  // Reads in flight plus buffered pixels never exceed the buffer depth.
  assign used       = {1'b0, count} + UW'($countones(vld));
  assign issue      = (state == READOUT) && (rd_cnt < NUM_PIX) && (used < UW'(FIFO_DEPTH));
  assign pix_valid  = !empty;
  assign pop        = pix_valid && pix_ready;
  assign frame_done = (state == READOUT) && pop && (out_cnt == LAST_PIX);
  assign busy       = (state != IDLE);
  // The read address is presented in the issue cycle so data lands exactly RD_LAT later.
  assign bram_raddr = issue ? rd_cnt[ADDR_W-1:0] : raddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      vld        <= '0;
      raddr_q    <= '0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      overrun    <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      vld     <= RD_LAT'({vld, issue});
      if (issue) begin
        raddr_q <= rd_cnt[ADDR_W-1:0];
        rd_cnt  <= rd_cnt + 1'b1;
      end
      if (pop) out_cnt <= out_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            wr_cnt  <= '0;
            overrun <= 1'b0;
          end else if (new_data) begin
            overrun <= 1'b1;
          end
        end
        LOAD: begin
          if (new_data) begin
            bram_we    <= 1'b1;
            bram_waddr <= wr_cnt[ADDR_W-1:0];
            bram_wdata <= image_in;
            wr_cnt     <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_PIX) begin
              state   <= READOUT;
              rd_cnt  <= '0;
              out_cnt <= '0;
            end
          end
        end
        READOUT: begin
          if (new_data) overrun <= 1'b1;
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (vld[RD_LAT-1]),
    .din  (bram_rdata),
    .pop  (pix_ready),
    .dout (pix_out),
    .count(count),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed bench for image_frame_sequencer with a 16-pixel frame and a 2-cycle BRAM model.
module tb_image_frame_sequencer;
  import frame_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] image_in = '0;
  logic       new_data = 1'b0;
  logic       bram_we;
  logic [3:0] bram_waddr;
  logic [7:0] bram_wdata;
  logic [3:0] bram_raddr;
  logic [7:0] bram_rdata = '0;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];
  logic [7:0] d1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    d1         <= mem[bram_raddr];
    bram_rdata <= d1;
  end

  image_frame_sequencer #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .FRAME_PIXELS(16),
    .RD_LAT      (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .image_in  (image_in),
    .new_data  (new_data),
    .bram_we   (bram_we),
    .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata),
    .bram_raddr(bram_raddr),
    .bram_rdata(bram_rdata),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input logic [7:0] base, input logic strobe_with_start);
    start    = 1'b1;
    new_data = strobe_with_start;
    image_in = 8'hEE;
    #1;
    tick();
    start    = 1'b0;
    new_data = 1'b0;
    #1;
    chk("overrun_after_start", overrun, 0);
    chk("we_after_start", bram_we, 0);
    chk("busy_load", busy, 1);
    for (int i = 0; i < 16; i++) begin
      new_data = 1'b1;
      image_in = 8'(base + i);
      #1;
      if (i > 0) begin
        chk("we", bram_we, 1);
        chk("waddr", bram_waddr, 32'(i - 1));
        chk("wdata", bram_wdata, 32'(8'(base + i - 1)));
      end
      tick();
    end
    new_data = 1'b0;
    #1;
    chk("we_last", bram_we, 1);
    chk("waddr_last", bram_waddr, 15);
    chk("wdata_last", bram_wdata, 32'(8'(base + 15)));
    chk("state_readout", dut.state, READOUT);
  endtask

  task automatic readout_full(input logic [7:0] base, input int strobe_at);
    pix_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      new_data = (strobe_at >= 0) && (k == strobe_at);
      #1;
      chk("pix_valid", pix_valid, 32'((k >= 3) && (k <= 18)));
      if ((k >= 3) && (k <= 18)) chk("pix_out", pix_out, 32'(8'(base + k - 3)));
      chk("frame_done", frame_done, 32'(k == 18));
      chk("busy_ro", busy, 32'(k < 19));
      if ((strobe_at >= 0) && (k == strobe_at + 1)) begin
        chk("we_ro_strobe", bram_we, 0);
        chk("overrun_ro", overrun, 1);
      end
      if (k < 19) tick();
    end
    new_data = 1'b0;
  endtask

  initial begin
    int got;
    logic hs;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_raddr", bram_raddr, 0);
    chk("rst_waddr", bram_waddr, 0);
    tick();

    // Back-to-back load, full-rate readout
    load_frame(8'hA0, 1'b0);
    readout_full(8'hA0, -1);
    tick();

    // Random backpressure
    load_frame(8'h50, 1'b0);
    got = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      pix_ready = 1'($urandom_range(0, 1));
      #1;
      chk("credit", 32'(dut.used <= 4), 1);
      chk("fifo_count", 32'(dut.u_fifo.count <= 4), 1);
      hs = pix_valid && pix_ready;
      if (hs) begin
        chk("rand_pix", pix_out, 32'(8'(8'h50 + got)));
        chk("rand_done", frame_done, 32'(got == 15));
        got++;
      end else begin
        chk("rand_done_idle", frame_done, 0);
      end
      tick();
    end
    chk("rand_count", got, 16);
    pix_ready = 1'b1;
    #1;
    chk("rand_busy_end", busy, 0);
    chk("rand_valid_end", pix_valid, 0);
    tick();

    // Strobe in IDLE, then strobe during READOUT
    new_data = 1'b1;
    #1;
    tick();
    new_data = 1'b0;
    #1;
    chk("idle_strobe_we", bram_we, 0);
    chk("idle_strobe_overrun", overrun, 1);
    tick();
    load_frame(8'h10, 1'b0);
    readout_full(8'h10, 5);
    tick();

    // Reset while pixel 7 is handshaking
    load_frame(8'h30, 1'b0);
    pix_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      #1;
      chk("pre_rst_valid", pix_valid, 32'(k >= 3));
      if (k >= 3) chk("pre_rst_pix", pix_out, 32'(8'(8'h30 + k - 3)));
      chk("pre_rst_done", frame_done, 0);
      if (k == 10) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_overrun", overrun, 0);
    tick();

    // Strobe coinciding with start, then a fresh frame
    load_frame(8'hC0, 1'b1);
    readout_full(8'hC0, -1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
